uart_fifo_tx: RTL
=================

Name: uart_fifo_tx

Overview:
- UART 8N1 transmitter that drains bytes from the single-clock byte FIFO's output port and serializes them onto a TX line.
- Acts as the reader on the FIFO's request/pulse handshake: it raises a request, the FIFO answers with a one-cycle valid pulse carrying the byte, and the transmitter sends the frame.
- Sits between the comm-side FIFO and the board serial pin.

Parameters:
- CLOCKS_PER_BIT, 104, comm_clock cycles per UART bit; legal range >= 2.

Ports:
- comm_clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; state cleared immediately while 0.
- enable  input  1  when 1, the block may request new bytes; it does not abort a frame already in progress.
- fifo_ready  output  1  registered request to the FIFO (drives FIFO out_ready).
- fifo_valid  input  1  one-cycle pulse from the FIFO, byte present on fifo_data.
- fifo_data  input  8  byte from the FIFO; sampled only in the cycle fifo_valid=1.
- tx  output  1  serial line, idle high; registered.
- busy  output  1  1 while a frame (start, data, or stop bit) is on the line.

Behaviour:
- Reset values (reset=0, asynchronous): tx=1, fifo_ready=0, busy=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- States: IDLE, WAIT, START, DATA, STOP.
- IDLE:
  - enable=1 -> fifo_ready<=1, go to WAIT.
  - Otherwise stay in IDLE with fifo_ready=0.
- WAIT:
  - fifo_ready<=enable on each edge.
  - fifo_valid=1 is accepted regardless of enable, which covers a pop already in flight when enable drops.
  - On acceptance, at the same edge: shift<=fifo_data, fifo_ready<=0, tx<=0, busy<=1, cycle counter<=CLOCKS_PER_BIT-1, go to START.
  - Dropping fifo_ready at the same edge guarantees exactly one pop per request. The FIFO does not pop while its valid is high, and ready is already low in the following cycle.
- START, DATA, STOP: each bit holds for exactly CLOCKS_PER_BIT cycles. The counter decrements each cycle, and the bit advances when the counter reaches 0.
- START -> DATA: tx<=shift[0], bit counter<=0.
- DATA:
  - Data is sent LSB first; shift right on each bit advance.
  - After bit 7 completes: tx<=1, go to STOP.
- STOP:
  - tx=1 for CLOCKS_PER_BIT cycles.
  - At expiry: busy<=0, fifo_ready<=enable, and state<=WAIT if enable=1, else IDLE.
- Frame length: exactly 10*CLOCKS_PER_BIT cycles, counted from tx falling to the end of the stop bit.
- Back-to-back with a non-empty FIFO: tx stays high for CLOCKS_PER_BIT+2 cycles between consecutive start bits' preceding stop start and the next start. That is a 2-cycle request/response gap after the stop bit.
- Empty FIFO: remain in WAIT with fifo_ready=1 indefinitely. tx=1, busy=0.
- fifo_valid while not in WAIT is ignored; with a conforming FIFO it cannot occur.
- fifo_data is don't-care outside the valid cycle.
- Mid-frame reset:
  - tx returns high asynchronously; the byte is lost and the FIFO is not re-read.
  - After release, fifo_ready rises at the first clock edge if enable=1.
- enable falling mid-frame: the frame completes normally; no new request is made.
- Counter width: $clog2(CLOCKS_PER_BIT). Bit counter width: 3 bits. No wrap beyond bit 7.

Test Plan:
- CLOCKS_PER_BIT=4, FIFO preloaded with 0xA5, enable=1 -> fifo_ready high 1 cycle after reset release. tx sequence (4 cycles per bit): 0, 1,0,1,0,0,1,0,1, 1. busy high for 40 cycles. Exactly one FIFO pop.
- FIFO loaded with 0x00, 0xFF, 0x3C -> three frames in order. Each stop-bit-start to next start-bit is 4+2=6 high cycles. Read pointer advances by exactly 3. FIFO empty at end.
- Empty FIFO, enable=1 for 50 cycles -> fifo_ready=1 and tx=1 throughout, busy=0. Push 0x55 -> frame 0,1,0,1,0,1,0,1,0,1 starts within 3 cycles of the push completing.
- Assert reset=0 during DATA bit 3 of 0x81 -> tx=1, busy=0, fifo_ready=0 immediately without a clock edge. After release: a fresh request; the next FIFO byte is sent, not 0x81.
- enable dropped the same cycle fifo_ready is seen by the FIFO -> the resulting fifo_valid pulse is still accepted and the byte transmitted. Afterward fifo_ready stays 0 and the state is IDLE.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// UART 8N1 transmitter: requests bytes from a request/pulse FIFO port
// and serializes them LSB first onto an idle-high TX line.
module uart_fifo_tx #(
    parameter int CLOCKS_PER_BIT = 104
) (
    input  logic       comm_clock,
    input  logic       reset,
    input  logic       enable,
    output logic       fifo_ready,
    input  logic       fifo_valid,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_tx;
    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;

    state_t          w_state;
    logic            w_ready;
    logic            w_tx;
    logic            w_busy;
    logic [CW-1:0]   w_cnt;
    logic [2:0]      w_bit;
    logic [7:0]      w_shift;
    logic            w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state;
            r_ready <= w_ready;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
        end
    end

    always_comb begin
        w_state = r_state;
        w_ready = r_ready;
        w_tx    = r_tx;
        w_busy  = r_busy;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        unique case (r_state)
            S_IDLE: begin
                w_ready = enable;
                if (enable) begin
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                w_ready = enable;
                // An in-flight pop is taken even if enable just dropped
                if (fifo_valid) begin
                    w_shift = fifo_data;
                    w_ready = 1'b0;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                    w_cnt   = LAST;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    w_cnt   = LAST;
                    w_tx    = r_shift[0];
                    w_bit   = 3'd0;
                    w_state = S_DATA;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    w_cnt = LAST;
                    if (r_bit == 3'd7) begin
                        w_tx    = 1'b1;
                        w_state = S_STOP;
                    end else begin
                        w_shift = {1'b0, r_shift[7:1]};
                        w_tx    = r_shift[1];
                        w_bit   = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    w_busy  = 1'b0;
                    w_ready = enable;
                    w_state = enable ? S_WAIT : S_IDLE;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_ready = 1'b0;
            end
        endcase
    end

    assign fifo_ready = r_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;

endmodule
